// File: rtl/nibble_sub_pkg.sv
// ============================================================================
// Module      : nibble_sub_pkg
// Description : Shared types and constants for the multi-nibble sequential
//               subtractor controller (state encoding, nibble width, counter
//               width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_sub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a nibble index 0..n-1. The lower bound of 1 bit keeps
  // the counter a legal vector for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_sub_seq_ctrl.sv
// ============================================================================
// Module      : nibble_sub_seq_ctrl
// Description : FSM and nibble counter for nibble_sub_seq. Produces the
//               load / shift / last strobes used by the datapath.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               in_valid        - operand pair offered
//               out_ready       - consumer takes result
//               o_in_ready      - accepting operands (IDLE)
//               o_out_valid     - result available (DONE)
//               o_load          - operands latched at this edge
//               o_shift         - one nibble processed at this edge (RUN)
//               o_last          - this shift is the final nibble
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_sub_seq_ctrl
  import nibble_sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  output logic o_in_ready,
  output logic o_out_valid,
  output logic o_load,
  output logic o_shift,
  output logic o_last
);

  localparam int CW = cnt_width(NIBBLES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_load) begin
        r_cnt <= '0;
      end else if (o_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_load      = 1'b0;
    o_shift     = 1'b0;
    o_last      = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        if (in_valid) begin
          o_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        o_shift = 1'b1;
        if (r_cnt == CW'(NIBBLES - 1)) begin
          o_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nibble_sub_seq.sv
// ============================================================================
// Module      : nibble_sub_seq
// Description : Multi-nibble sequential subtractor controller. Feeds an
//               external 4-bit borrow-ripple subtractor one nibble per cycle,
//               LSB first, chaining the borrow, and returns the full-width
//               difference and final borrow over a valid/ready handshake.
// Ports       : clk, rst                - clock, synchronous active-high reset
//               in_valid/in_ready       - operand handshake
//               op_a, op_b, bin         - minuend, subtrahend, borrow-in
//               sub_a, sub_b, sub_bin   - to the external subtractor
//               sub_d, sub_bout         - from the external subtractor
//               out_valid/out_ready     - result handshake
//               diff, bout              - result and final borrow
//               zero, ovf               - result flags (SUBSEQ_FLAGS_EN only)
// Config      : SUBSEQ_FLAGS_EN - adds the zero / signed-overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_sub_seq
  import nibble_sub_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NIBBLES-1:0]    op_a,
  input  logic [4*NIBBLES-1:0]    op_b,
  input  logic                    bin,
  output logic [NIBBLE_W-1:0]     sub_a,
  output logic [NIBBLE_W-1:0]     sub_b,
  output logic                    sub_bin,
  input  logic [NIBBLE_W-1:0]     sub_d,
  input  logic                    sub_bout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NIBBLES-1:0]    diff,
`ifdef SUBSEQ_FLAGS_EN
  output logic                    zero,
  output logic                    ovf,
`endif
  output logic                    bout
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic         w_load;
  logic         w_shift;
  logic         w_last;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_diff;
  logic         r_borrow;
  logic [W-1:0] w_diff_nxt;

  nibble_sub_seq_ctrl #(
    .NIBBLES (NIBBLES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .out_ready   (out_ready),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .o_load      (w_load),
    .o_shift     (w_shift),
    .o_last      (w_last)
  );

  // Each returned nibble enters at the top; after NIBBLES shifts the first
  // (least significant) nibble has reached the bottom.
  assign w_diff_nxt = {sub_d, r_diff[W-1:NIBBLE_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_load) begin
      r_a      <= op_a;
      r_b      <= op_b;
      r_borrow <= bin;
    end else if (w_shift) begin
      r_a      <= r_a >> NIBBLE_W;
      r_b      <= r_b >> NIBBLE_W;
      r_diff   <= w_diff_nxt;
      r_borrow <= sub_bout;
    end
  end

  assign sub_a   = w_shift ? r_a[NIBBLE_W-1:0] : '0;
  assign sub_b   = w_shift ? r_b[NIBBLE_W-1:0] : '0;
  assign sub_bin = w_shift & r_borrow;
  assign diff    = r_diff;
  assign bout    = r_borrow;

`ifdef SUBSEQ_FLAGS_EN
  // Operand sign bits are kept separately because the shift registers have
  // lost them by the time the final difference nibble arrives.
  logic r_a_msb;
  logic r_b_msb;
  logic r_zero;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= op_a[W-1];
      r_b_msb <= op_b[W-1];
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_diff_nxt == '0);
      r_ovf  <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff_nxt[W-1]);
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nibble_sub_seq.sv
// ============================================================================
// Module      : tb_nibble_sub_seq
// Description : Directed self-checking bench for nibble_sub_seq (NIBBLES=4)
//               with a behavioural 4-bit borrow-ripple subtractor attached.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_sub_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         bin;
  logic [3:0]   sub_a;
  logic [3:0]   sub_b;
  logic         sub_bin;
  logic [3:0]   sub_d;
  logic         sub_bout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUBSEQ_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;

  nibble_sub_seq #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .bin       (bin),
    .sub_a     (sub_a),
    .sub_b     (sub_b),
    .sub_bin   (sub_bin),
    .sub_d     (sub_d),
    .sub_bout  (sub_bout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef SUBSEQ_FLAGS_EN
    .zero      (zero),
    .ovf       (ovf),
`endif
    .bout      (bout)
  );

  // External 4-bit subtractor: {borrow, d} = a - b - bin.
  logic [4:0] w_sub5;
  always_comb begin
    w_sub5   = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
    sub_d    = w_sub5[3:0];
    sub_bout = w_sub5[4];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair from IDLE, waits for out_valid, checks latency
  // and result, then retires with out_ready.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic [W-1:0] exp_d, input logic exp_bo);
    int lat;
    op_a     = a;
    op_b     = b;
    bin      = bi;
    in_valid = 1'b1;
    step();                       // acceptance edge E0
    in_valid = 1'b0;
    chk({tag, "_sub_a0"}, 32'(sub_a), 32'(a[3:0]));
    chk({tag, "_sub_bin0"}, 32'(sub_bin), 32'(bi));
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, NIBBLES);
    chk({tag, "_diff"}, 32'(diff), 32'(exp_d));
    chk({tag, "_bout"}, 32'(bout), 32'(exp_bo));
  endtask

  task automatic retire(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ret_valid"}, 32'(out_valid), 0);
    chk({tag, "_ret_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic        stable;
    logic        seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    bin       = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
    chk("rst_sub", {23'b0, sub_a, sub_b, sub_bin}, 0);
`ifdef SUBSEQ_FLAGS_EN
    chk("rst_flags", {30'b0, zero, ovf}, 0);
`endif
    rst = 1'b0;
    step();

    do_op("v1", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    retire("v1");

    do_op("v2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    retire("v2");

    do_op("v3", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1);
`ifdef SUBSEQ_FLAGS_EN
    chk("v3_zero", 32'(zero), 0);
    chk("v3_ovf", 32'(ovf), 0);
`endif
    retire("v3");

    do_op("v4", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
`ifdef SUBSEQ_FLAGS_EN
    chk("v4_zero", 32'(zero), 0);
    chk("v4_ovf", 32'(ovf), 1);
`endif
    retire("v4");

    do_op("v5", 16'h4321, 16'h4321, 1'b0, 16'h0000, 1'b0);
`ifdef SUBSEQ_FLAGS_EN
    chk("v5_zero", 32'(zero), 1);
    chk("v5_ovf", 32'(ovf), 0);
`endif
    retire("v5");

    // Back-pressure: result held for 5 cycles, new offers ignored.
    do_op("bp", 16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0);
    op_a     = 16'hFFFF;
    op_b     = 16'h0000;
    bin      = 1'b0;
    in_valid = 1'b1;
    stable   = 1'b1;
    repeat (5) begin
      step();
      if (diff !== 16'h4B4B || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    in_valid = 1'b0;
    chk("bp_hold_stable", 32'(stable), 1);
    retire("bp");

    // Reset two cycles into RUN aborts the operation.
    op_a     = 16'h1234;
    op_b     = 16'h0234;
    bin      = 1'b0;
    in_valid = 1'b1;
    step();                       // accept
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_diff", 32'(diff), 0);
    seen_valid = 1'b0;
    repeat (6) begin
      step();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    chk("abort_no_valid", 32'(seen_valid), 0);

    do_op("post", 16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0);
    retire("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
